// File: rtl/bus_arbiter_rr_if.sv
// Bus bundle between the requesting masters and bus_arbiter_rr.
// master: requester side; slave: the arbiter that consumes requests and drives the muxed bus.
interface bus_arbiter_rr_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int N_SLAVES  = 5
);
  localparam int OW = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0]        request;
  logic [N_MASTERS-1:0]        busbusy;
  logic [N_MASTERS*ADDR_W-1:0] address_in;
  logic [N_MASTERS*DATA_W-1:0] data_in;
  logic [N_MASTERS-1:0]        grant;
  logic [OW-1:0]               owner;
  logic                        bus_valid;
  logic [ADDR_W-1:0]           bus_address;
  logic [DATA_W-1:0]           bus_data;
  logic [N_SLAVES-1:0]         slave_sel;
  logic                        decode_err;
  logic                        protocol_err;
  logic                        wd_revoke;

  modport master (
    output request, busbusy, address_in, data_in,
    input  grant, owner, bus_valid, bus_address, bus_data,
    input  slave_sel, decode_err, protocol_err, wd_revoke
  );

  modport slave (
    input  request, busbusy, address_in, data_in,
    output grant, owner, bus_valid, bus_address, bus_data,
    output slave_sel, decode_err, protocol_err, wd_revoke
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with registered address/data mux and one-hot slave decode.
// Optional idle-owner watchdog enabled by defining ARB_WATCHDOG_EN.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int QUANTUM   = 4,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int N_SLAVES  = 5,
  parameter int WD_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_rr_if.slave bus
);
  localparam int OW = $clog2(N_MASTERS);
  localparam int TW = $clog2(QUANTUM + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  if (N_MASTERS < 2 || N_MASTERS > 8 || QUANTUM < 1 || QUANTUM > 15 ||
      WD_CYCLES < 1 || N_SLAVES < 1) begin : g_bad_params
    $error("bus_arbiter_rr: parameter out of range");
  end

  logic [1:0]        state;
  logic [TW-1:0]     tenure;
  logic [OW-1:0]     winner;
  logic [OW-1:0]     cand;
  logic              found;
  logic              any_req;
  logic              owner_busy;
  logic              exit_grant;
  logic              drive_valid;
  logic              in_range;
  logic              wd_fire;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_data;

  assign any_req    = |bus.request;
  assign owner_busy = bus.busbusy[bus.owner];

  // Rotating search from owner+1; the releasing owner is checked last.
  always_comb begin
    winner = bus.owner;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = OW'((int'(bus.owner) + k) % N_MASTERS);
      if (!found && bus.request[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    owner_addr = '0;
    owner_data = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (bus.owner == OW'(i)) begin
        owner_addr = bus.address_in[i*ADDR_W +: ADDR_W];
        owner_data = bus.data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign exit_grant = (state == ST_GRANT) &&
                      (!bus.request[bus.owner] || tenure == TW'(QUANTUM) || wd_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bus.grant <= '0;
      bus.owner <= OW'(N_MASTERS - 1);
      tenure    <= '0;
    end else begin
      case (state)
        ST_GRANT: begin
          if (exit_grant) begin
            state     <= ST_GAP;
            bus.grant <= '0;
            tenure    <= '0;
          end else begin
            tenure <= tenure + TW'(1);
          end
        end
        ST_IDLE, ST_GAP: begin
          if (any_req) begin
            state     <= ST_GRANT;
            bus.owner <= winner;
            bus.grant <= N_MASTERS'(1) << winner;
            tenure    <= TW'(1);
          end else begin
            state  <= ST_IDLE;
            tenure <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus.grant <= '0;
          tenure    <= '0;
        end
      endcase
    end
  end

  assign drive_valid = (state == ST_GRANT) && bus.grant[bus.owner] && owner_busy;
  assign in_range    = int'(owner_addr) < N_SLAVES;

  // Bus side lags the owner's busbusy by one cycle; non-owner drivers are only flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_valid    <= 1'b0;
      bus.bus_address  <= '0;
      bus.bus_data     <= '0;
      bus.slave_sel    <= '0;
      bus.decode_err   <= 1'b0;
      bus.protocol_err <= 1'b0;
    end else begin
      bus.bus_valid    <= drive_valid;
      bus.bus_address  <= drive_valid ? owner_addr : '0;
      bus.bus_data     <= drive_valid ? owner_data : '0;
      bus.slave_sel    <= (drive_valid && in_range) ? (N_SLAVES'(1) << owner_addr) : '0;
      bus.decode_err   <= drive_valid && !in_range;
      bus.protocol_err <= |(bus.busbusy & ~bus.grant);
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);

  logic [WW-1:0] wd_cnt;

  assign wd_fire = (state == ST_GRANT) && !owner_busy && (wd_cnt == WW'(WD_CYCLES - 1));

  // Counts consecutive idle-owner cycles; revoke pulse coincides with the first GAP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= '0;
      bus.wd_revoke <= 1'b0;
    end else begin
      bus.wd_revoke <= wd_fire;
      if (state != ST_GRANT || owner_busy || exit_grant) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end
`else
  assign wd_fire       = 1'b0;
  assign bus.wd_revoke = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_bus_arbiter_rr;
  localparam int NM = 4;
  localparam int Q  = 4;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NS = 5;
  localparam int WD = 2;

  logic clk;
  logic rst;

  bus_arbiter_rr_if #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS)) bus_if ();

  bus_arbiter_rr #(
    .N_MASTERS(NM), .QUANTUM(Q), .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .WD_CYCLES(WD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [NM-1:0]    cur_req;
  logic [NM-1:0]    cur_busy;
  logic [NM*AW-1:0] cur_addr;
  logic [NM*DW-1:0] cur_data;
  logic [NM*AW-1:0] addr_v;
  logic [NM*DW-1:0] data_v;

  // Model: who holds the bus and for how long, plus predicted registered bus outputs.
  logic [NM-1:0] m_grant;
  int            m_owner;
  int            m_held;
  int            m_idle;
  logic          e_valid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [NS-1:0] e_sel;
  logic          e_derr;
  logic          e_perr;
  logic          e_wd;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM-1:0] busy,
                               input logic [NM*AW-1:0] addr, input logic [NM*DW-1:0] data);
    cur_req  = req;
    cur_busy = busy;
    cur_addr = addr;
    cur_data = data;
    bus_if.request    = req;
    bus_if.busbusy    = busy;
    bus_if.address_in = addr;
    bus_if.data_in    = data;
  endtask

  task automatic modelReset();
    m_grant = '0;
    m_owner = NM - 1;
    m_held  = 0;
    m_idle  = 0;
    e_valid = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_sel   = '0;
    e_derr  = 1'b0;
    e_perr  = 1'b0;
    e_wd    = 1'b0;
  endtask

  task automatic modelStep();
    logic          v;
    logic [AW-1:0] a;
    logic          rel;
    int            c;
    v       = (m_grant != 0) && cur_busy[m_owner];
    a       = cur_addr[m_owner*AW +: AW];
    e_valid = v;
    e_addr  = v ? a : '0;
    e_data  = v ? cur_data[m_owner*DW +: DW] : '0;
    e_sel   = (v && int'(a) < NS) ? NS'(1 << a) : '0;
    e_derr  = v && int'(a) >= NS;
    e_perr  = |(cur_busy & ~m_grant);
    e_wd    = 1'b0;
    if (m_grant != 0) begin
      rel = !cur_req[m_owner] || m_held == Q;
`ifdef ARB_WATCHDOG_EN
      if (!cur_busy[m_owner] && m_idle + 1 == WD) begin
        rel  = 1'b1;
        e_wd = 1'b1;
      end
`endif
      if (rel) begin
        m_grant = '0;
        m_held  = 0;
        m_idle  = 0;
      end else begin
        m_held++;
        m_idle = cur_busy[m_owner] ? 0 : m_idle + 1;
      end
    end else if (cur_req != 0) begin
      for (int k = 1; k <= NM; k++) begin
        c = (m_owner + k) % NM;
        if (cur_req[c]) begin
          m_owner = c;
          m_grant = NM'(1 << c);
          m_held  = 1;
          m_idle  = 0;
          break;
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("grant",        32'(bus_if.grant),        32'(m_grant));
    checkOutput("owner",        32'(bus_if.owner),        32'(m_owner));
    checkOutput("bus_valid",    32'(bus_if.bus_valid),    32'(e_valid));
    checkOutput("bus_address",  32'(bus_if.bus_address),  32'(e_addr));
    checkOutput("bus_data",     32'(bus_if.bus_data),     32'(e_data));
    checkOutput("slave_sel",    32'(bus_if.slave_sel),    32'(e_sel));
    checkOutput("decode_err",   32'(bus_if.decode_err),   32'(e_derr));
    checkOutput("protocol_err", 32'(bus_if.protocol_err), 32'(e_perr));
    checkOutput("wd_revoke",    32'(bus_if.wd_revoke),    32'(e_wd));
  endtask

  // Called at a falling edge: check, drive the next inputs, advance model and DUT one cycle.
  task automatic runCycle(input logic [NM-1:0] req, input logic [NM-1:0] busy_mask,
                          input logic [NM-1:0] viol);
    compareAll();
    applyStimulus(req, (m_grant & req & busy_mask) | viol, addr_v, data_v);
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus('0, '0, '0, '0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  logic [NM-1:0] rq;
  logic [NM-1:0] mask;
  logic [NM-1:0] viol;
  logic [NM-1:0] exp_g;

  initial begin
    rst    = 1'b1;
    addr_v = '0;
    data_v = '0;
    applyStimulus('0, '0, '0, '0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_grant", 32'(bus_if.grant), 32'h0);
    checkOutput("reset_owner", 32'(bus_if.owner), 32'(NM - 1));
    checkOutput("reset_valid", 32'(bus_if.bus_valid), 32'h0);

    // Sole requester: four grant cycles, one gap, then re-grant.
    for (int c = 0; c < 11; c++) begin
      runCycle(4'b0010, 4'hF, 4'h0);
      exp_g = (c % 5 < 4) ? 4'b0010 : 4'b0000;
      checkOutput("t1_grant", 32'(bus_if.grant), 32'(exp_g));
    end

    // All requesting: rotation 0,1,2,3,0 with quantum-length tenures and single gaps.
    doReset();
    for (int c = 0; c < 21; c++) begin
      runCycle(4'b1111, 4'hF, 4'h0);
      exp_g = (c % 5 < 4) ? 4'(1 << ((c / 5) % 4)) : 4'b0000;
      checkOutput("t2_grant", 32'(bus_if.grant), 32'(exp_g));
    end

    // Owner 2 drives a valid address, then an out-of-range one.
    doReset();
    addr_v = 12'(3 << 6);
    data_v = 32'h0002_0000;
    runCycle(4'b0100, 4'hF, 4'h0);
    runCycle(4'b0100, 4'hF, 4'h0);
    checkOutput("t3_valid", 32'(bus_if.bus_valid), 32'h1);
    checkOutput("t3_addr",  32'(bus_if.bus_address), 32'h3);
    checkOutput("t3_data",  32'(bus_if.bus_data), 32'h02);
    checkOutput("t3_sel",   32'(bus_if.slave_sel), 32'b01000);
    addr_v = 12'(6 << 6);
    runCycle(4'b0100, 4'hF, 4'h0);
    checkOutput("t4_derr",  32'(bus_if.decode_err), 32'h1);
    checkOutput("t4_sel",   32'(bus_if.slave_sel), 32'h0);
    checkOutput("t4_valid", 32'(bus_if.bus_valid), 32'h1);

    // Non-owner drives the bus while master 0 holds the grant.
    doReset();
    runCycle(4'b0001, 4'h0, 4'h0);
    runCycle(4'b0001, 4'h0, 4'b0100);
    checkOutput("t5_perr",  32'(bus_if.protocol_err), 32'h1);
    checkOutput("t5_valid", 32'(bus_if.bus_valid), 32'h0);

    // Asynchronous reset in the second grant cycle.
    doReset();
    addr_v = '0;
    runCycle(4'b0001, 4'hF, 4'h0);
    runCycle(4'b0001, 4'hF, 4'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_grant", 32'(bus_if.grant), 32'h0);
    checkOutput("t6_valid", 32'(bus_if.bus_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus('0, '0, '0, '0);
    runCycle(4'b1001, 4'h0, 4'h0);
    checkOutput("t6_first", 32'(bus_if.grant), 32'b0001);
`ifdef ARB_WATCHDOG_EN
    runCycle(4'b1001, 4'h0, 4'h0);
    runCycle(4'b1001, 4'h0, 4'h0);
    checkOutput("t6_wd",       32'(bus_if.wd_revoke), 32'h1);
    checkOutput("t6_wd_grant", 32'(bus_if.grant), 32'h0);
`endif

    // Randomized traffic with sticky requests, idle owners and stray drivers.
    doReset();
    rq = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(5) == 0) rq[i] = ~rq[i];
      end
      mask   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      viol   = ($urandom_range(9) == 0) ? 4'(1 << $urandom_range(3)) : 4'h0;
      addr_v = 12'($urandom);
      data_v = 32'($urandom);
      runCycle(rq, mask, viol);
    end
    compareAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
